// File: rtl/serial_tx_pkg.sv
// Shared definitions for the memory-mapped serial transmitter.
// Contents: register indices, STATUS/CONTROL bit positions, STATUS
// layout struct and the transmit FSM state type.
package serial_tx_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BAUD_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;

  // Register window decoded from address_out[1:0]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_BAUD    = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVR   = 6;
  localparam int unsigned ST_IRQ   = 7;

  // CONTROL bit positions
  localparam int unsigned CTL_IRQ_EN = 0;
  localparam int unsigned CTL_FLUSH  = 1;

  // STATUS read layout, MSB first
  typedef struct packed {
    logic       irq;
    logic       ovr;
    logic [2:0] rsvd;
    logic       busy;
    logic       empty;
    logic       full;
  } status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/serial_tx_adapter_sync_fifo.sv
// Synchronous FIFO used as the transmit byte queue.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   i_push/i_wdata write one entry (ignored when full unless popping too)
//   i_pop/o_rdata  read one entry (o_rdata is the head, valid when !o_empty)
//   i_flush        discard all entries
//   o_full/o_empty/o_count  occupancy after the current edge
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // A push into a full queue is legal when the head leaves on the same edge
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  // Pointers; flush snaps the read pointer onto the write pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (i_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/serial_tx_adapter.sv
// Memory-mapped 8N1 serial transmitter on the 6502 data bus.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   chip_en, wrt_en           bus select and write strobe
//   register_select[1:0]      TXDATA / STATUS / CONTROL / BAUD
//   data_in[7:0]              CPU write data
//   data_out[7:0]             read data, combinational from register_select
//   tx_out                    serial line, idles high
//   irq_n                     active-low "transmitter drained" interrupt
module serial_tx_adapter
  import serial_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [7:0]  DEFAULT_DIV = 8'd15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chip_en,
  input  logic       wrt_en,
  input  logic [1:0] register_select,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx_out,
  output logic       irq_n
);

  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);

  // Bus decode
  logic w_wr;
  logic w_push;
  logic w_status_wr;
  logic w_ctrl_wr;
  logic w_baud_wr;
  logic w_flush;

  assign w_wr        = chip_en & wrt_en;
  assign w_push      = w_wr & (register_select == REG_TXDATA);
  assign w_status_wr = w_wr & (register_select == REG_STATUS);
  assign w_ctrl_wr   = w_wr & (register_select == REG_CONTROL);
  assign w_baud_wr   = w_wr & (register_select == REG_BAUD);
  assign w_flush     = w_ctrl_wr & data_in[CTL_FLUSH];

  // Transmit queue
  logic [DATA_W-1:0] w_rdata;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_AW:0]  w_count;
  logic              w_pop;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (data_in),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Registers
  tx_state_t            r_state;
  tx_state_t            w_state_n;
  logic [BAUD_W-1:0]    r_timer;
  logic [BAUD_W-1:0]    w_timer_n;
  logic [BIT_IDX_W-1:0] r_bit;
  logic [BIT_IDX_W-1:0] w_bit_n;
  logic [DATA_W-1:0]    r_shift;
  logic [DATA_W-1:0]    w_shift_n;
  logic                 r_tx;
  logic                 w_tx_n;
  logic [BAUD_W-1:0]    r_baud;
  logic                 r_irq_en;
  logic                 r_ovr;
  logic                 r_irq;
  logic                 w_bit_end;
  logic [BAUD_W-1:0]    w_timer_dec;

  assign w_bit_end   = (r_timer == '0);
  assign w_timer_dec = r_timer - BAUD_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // FSM next state, bit timer, shifter and line level.
  // Each new bit reloads the timer from BAUD, so a divider change lands on the next bit.
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_n = 1'b1;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_rdata;
          w_timer_n = r_baud;
          w_state_n = START;
          w_tx_n    = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_n = DATA;
          w_timer_n = r_baud;
          w_bit_n   = '0;
          w_tx_n    = r_shift[0];
        end else begin
          w_timer_n = w_timer_dec;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_timer_n = r_baud;
          if (r_bit == BIT_IDX_W'(7)) begin
            w_state_n = STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_bit_n   = r_bit + BIT_IDX_W'(1);
            w_shift_n = {1'b0, r_shift[DATA_W-1:1]};
            w_tx_n    = r_shift[1];
          end
        end else begin
          w_timer_n = w_timer_dec;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          // Chain straight into the next start bit when more data is queued
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_rdata;
            w_timer_n = r_baud;
            w_state_n = START;
            w_tx_n    = 1'b0;
          end else begin
            w_state_n = IDLE;
            w_tx_n    = 1'b1;
          end
        end else begin
          w_timer_n = w_timer_dec;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_timer <= w_timer_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
    end
  end

  // CPU-visible control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_baud   <= DEFAULT_DIV;
      r_irq_en <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_baud_wr) begin
        r_baud <= data_in;
      end
      if (w_ctrl_wr) begin
        r_irq_en <= data_in[CTL_IRQ_EN];
      end
      // Overflow only when the push really had nowhere to go
      if (w_status_wr) begin
        r_ovr <= 1'b0;
      end else if (w_push & w_full & ~w_pop) begin
        r_ovr <= 1'b1;
      end
    end
  end

  // Drained interrupt: queue empty and FSM idle, one register stage late
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & (w_count == (FIFO_AW+1)'(0)) & (r_state == IDLE);
    end
  end

  // Read mux
  status_t w_status;

  always_comb begin
    w_status       = '0;
    w_status.irq   = r_irq;
    w_status.ovr   = r_ovr;
    w_status.busy  = (r_state != IDLE);
    w_status.empty = w_empty;
    w_status.full  = w_full;
  end

  always_comb begin
    data_out = '0;
    case (register_select)
      REG_TXDATA:  data_out = '0;
      REG_STATUS:  data_out = w_status;
      REG_CONTROL: data_out = {7'b0, r_irq_en};
      REG_BAUD:    data_out = r_baud;
      default:     data_out = '0;
    endcase
  end

  assign tx_out = r_tx;
  assign irq_n  = ~r_irq;

endmodule

// File: tb/tb_serial_tx_adapter.sv
// Directed self-checking bench for serial_tx_adapter.
module tb_serial_tx_adapter;

  localparam logic [1:0] A_TX   = 2'd0;
  localparam logic [1:0] A_ST   = 2'd1;
  localparam logic [1:0] A_CTL  = 2'd2;
  localparam logic [1:0] A_BAUD = 2'd3;

  logic       clk;
  logic       reset_n;
  logic       chip_en;
  logic       wrt_en;
  logic [1:0] register_select;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       tx_out;
  logic       irq_n;

  int vectors;
  int miscompares;

  serial_tx_adapter #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (8'd15)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .chip_en         (chip_en),
    .wrt_en          (wrt_en),
    .register_select (register_select),
    .data_in         (data_in),
    .data_out        (data_out),
    .tx_out          (tx_out),
    .irq_n           (irq_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; commits on the next rising edge
  task automatic bus_write(input logic [1:0] sel, input logic [7:0] d);
    register_select = sel;
    data_in         = d;
    chip_en         = 1'b1;
    wrt_en          = 1'b1;
    @(negedge clk);
    chip_en = 1'b0;
    wrt_en  = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    register_select = sel;
    chip_en         = 1'b1;
    wrt_en          = 1'b0;
    #1;
    check(tag, data_out, exp);
    chip_en = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k, input int bl);
    int idx;
    idx = k / bl;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // k counts cycles from the pop edge; caller sits at the falling edge for k0
  task automatic check_frame(input string tag, input logic [7:0] b, input int k0, input int bl);
    for (int k = k0; k < 10 * bl; k++) begin
      if (k > k0) @(negedge clk);
      check(tag, {7'b0, tx_out}, {7'b0, exp_bit(b, k, bl)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    chip_en         = 1'b0;
    wrt_en          = 1'b0;
    register_select = 2'd0;
    data_in         = 8'h00;
    reset_n         = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_tx", {7'b0, tx_out}, 8'h01);
    check("rst_irq_n", {7'b0, irq_n}, 8'h01);
    check_reg("rst_status", A_ST, 8'h02);
    check_reg("rst_baud", A_BAUD, 8'h0F);
    check_reg("rst_ctrl", A_CTL, 8'h00);
    check_reg("rst_txdata_rd", A_TX, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);

    // Single frame A5 at BAUD=3
    bus_write(A_BAUD, 8'h03);
    check_reg("baud_rd", A_BAUD, 8'h03);
    bus_write(A_TX, 8'hA5);
    check("a5_before_pop", {7'b0, tx_out}, 8'h01);
    @(negedge clk);
    check_reg("a5_status_busy", A_ST, 8'h06);
    check_frame("a5_frame", 8'hA5, 0, 4);
    check_reg("a5_status_k39", A_ST, 8'h06);
    @(negedge clk);
    check_reg("a5_status_done", A_ST, 8'h02);
    check("a5_tx_idle", {7'b0, tx_out}, 8'h01);

    // Back-to-back 00 then FF, no idle gap
    bus_write(A_TX, 8'h00);
    bus_write(A_TX, 8'hFF);
    check_frame("b2b_00", 8'h00, 0, 4);
    @(negedge clk);
    check_frame("b2b_ff", 8'hFF, 0, 4);
    @(negedge clk);
    check_reg("b2b_status_done", A_ST, 8'h02);

    // Fill with the line stalled, then overflow, OVR clear, flush
    bus_write(A_BAUD, 8'hFF);
    for (int i = 1; i <= 9; i++) bus_write(A_TX, 8'(i));
    check_reg("fill_status_full", A_ST, 8'h05);
    bus_write(A_TX, 8'h0A);
    check_reg("fill_status_ovr", A_ST, 8'h45);
    bus_write(A_ST, 8'h00);
    check_reg("fill_ovr_cleared", A_ST, 8'h05);
    bus_write(A_CTL, 8'h02);
    check_reg("fill_flushed", A_ST, 8'h06);
    check_reg("flush_reads_0", A_CTL, 8'h00);
    bus_write(A_BAUD, 8'h00);
    n = 0;
    while (n < 600) begin
      register_select = A_ST;
      chip_en         = 1'b1;
      wrt_en          = 1'b0;
      #1;
      if (data_out[2] == 1'b0) break;
      chip_en = 1'b0;
      @(negedge clk);
      n++;
    end
    chip_en = 1'b0;
    check_reg("fill_drain_status", A_ST, 8'h02);
    check("fill_drain_tx", {7'b0, tx_out}, 8'h01);

    // Flush mid-frame with three bytes queued
    @(negedge clk);
    bus_write(A_BAUD, 8'h03);
    bus_write(A_TX, 8'h11);
    bus_write(A_TX, 8'h22);
    bus_write(A_TX, 8'h33);
    bus_write(A_TX, 8'h44);
    bus_write(A_CTL, 8'h02);
    check_reg("flush3_status", A_ST, 8'h06);
    check_frame("flush3_frame", 8'h11, 3, 4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("flush3_no_more", {7'b0, tx_out}, 8'h01);
    end
    check_reg("flush3_done", A_ST, 8'h02);

    // BAUD=0: one cycle per bit
    bus_write(A_BAUD, 8'h00);
    bus_write(A_TX, 8'h5A);
    check("b0_before_pop", {7'b0, tx_out}, 8'h01);
    @(negedge clk);
    check_frame("b0_frame", 8'h5A, 0, 1);
    @(negedge clk);
    check_reg("b0_done", A_ST, 8'h02);

    // IRQ: enable, send one byte, then disable
    bus_write(A_CTL, 8'h01);
    @(negedge clk);
    check("irq_idle_low", {7'b0, irq_n}, 8'h00);
    check_reg("irq_idle_status", A_ST, 8'h82);
    bus_write(A_TX, 8'hC3);
    @(negedge clk);
    check("irq_cleared_by_tx", {7'b0, irq_n}, 8'h01);
    check_frame("irq_frame", 8'hC3, 0, 1);
    check("irq_high_in_stop", {7'b0, irq_n}, 8'h01);
    repeat (2) @(negedge clk);
    check("irq_after_stop", {7'b0, irq_n}, 8'h00);
    check_reg("irq_status_set", A_ST, 8'h82);
    bus_write(A_CTL, 8'h00);
    @(negedge clk);
    check("irq_disabled", {7'b0, irq_n}, 8'h01);
    check_reg("irq_status_clr", A_ST, 8'h02);

    // Reset in the middle of a frame
    bus_write(A_BAUD, 8'h03);
    bus_write(A_CTL, 8'h01);
    bus_write(A_TX, 8'h00);
    repeat (2) @(negedge clk);
    check("midrst_pre_tx", {7'b0, tx_out}, 8'h00);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_tx", {7'b0, tx_out}, 8'h01);
    check("midrst_irq_n", {7'b0, irq_n}, 8'h01);
    check_reg("midrst_status", A_ST, 8'h02);
    check_reg("midrst_baud", A_BAUD, 8'h0F);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_tx", {7'b0, tx_out}, 8'h01);
    check_reg("postrst_status", A_ST, 8'h02);
    check_reg("postrst_ctrl", A_CTL, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
